// File: rtl/max7219_chain_if.sv
// Host write channel of max7219_chain: one register write per valid/ready handshake.
interface max7219_chain_if #(
  parameter int unsigned DEV_W = 2
);
  logic             wr_valid;
  logic             wr_ready;
  logic             wr_bcast;
  logic [DEV_W-1:0] wr_dev;
  logic [3:0]       wr_addr;
  logic [7:0]       wr_data;

  modport master (output wr_valid, wr_bcast, wr_dev, wr_addr, wr_data, input wr_ready);
  modport slave  (input wr_valid, wr_bcast, wr_dev, wr_addr, wr_data, output wr_ready);
endinterface

// File: rtl/max7219_chain.sv
// Register-write driver for NUM_DEV daisy-chained MAX7219s over DIN/CLK/LOAD.
// Define MAX7219_AUTOINIT_EN to run the 13-write broadcast init after reset.
module max7219_chain #(
  parameter int unsigned NUM_DEV    = 4,
  parameter int unsigned CLK_DIV    = 10,
  parameter int unsigned LOAD_HOLD  = 2,
  parameter logic [3:0]  INTENSITY  = 4'd12,
  parameter logic [2:0]  SCAN_LIMIT = 3'd7,
  parameter logic [7:0]  DECODE     = 8'h00
) (
  input  logic           CLOCK_50,
  input  logic           rst_n,
  max7219_chain_if.slave wr,
  output logic           busy,
  output logic           init_done,
  output logic           max_din,
  output logic           max_clk,
  output logic           max_load
);
  localparam int unsigned HALF    = CLK_DIV / 2;
  localparam int unsigned FRAME_W = NUM_DEV * 16;
  localparam int unsigned DEV_W   = (NUM_DEV > 1) ? $clog2(NUM_DEV) : 1;
  localparam int unsigned TICK_W  = (HALF > 1) ? $clog2(HALF) : 1;
  localparam int unsigned BIT_W   = $clog2(FRAME_W);
  localparam int unsigned HOLD_W  = (LOAD_HOLD > 1) ? $clog2(LOAD_HOLD) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(HALF - 1);
  localparam logic [BIT_W-1:0]  BIT_FIRST = BIT_W'(FRAME_W - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LOAD_HOLD - 1);

  typedef enum logic [2:0] {S_INIT, S_IDLE, S_SCK_LO, S_SCK_HI, S_TAIL, S_LOAD} state_t;

  state_t              r_state;
  logic [TICK_W-1:0]   r_tick;
  logic [BIT_W-1:0]    r_bit;
  logic [HOLD_W-1:0]   r_hold;
  logic [FRAME_W-1:0]  r_frame;
  logic                r_ready, r_busy, r_done, r_din, r_sck, r_load;
  logic [FRAME_W-1:0]  w_frame;

  // Device 0 occupies the low word so it is shifted out last.
  function automatic logic [FRAME_W-1:0] build_frame(input logic bcast,
                                                     input logic [DEV_W-1:0] dev,
                                                     input logic [11:0] word);
    logic [FRAME_W-1:0] f;
    f = '0;
    for (int unsigned d = 0; d < NUM_DEV; d++)
      if (bcast || (dev == DEV_W'(d))) f[d*16 +: 16] = {4'h0, word};
    return f;
  endfunction

`ifdef MAX7219_AUTOINIT_EN
  logic [3:0] r_step;
  logic [3:0] w_step;

  function automatic logic [11:0] init_word(input logic [3:0] step);
    case (step)
      4'd0:    return 12'hF00;
      4'd1:    return {4'hB, 5'd0, SCAN_LIMIT};
      4'd2:    return {4'h9, DECODE};
      4'd3:    return {4'hA, 4'h0, INTENSITY};
      4'd4:    return 12'hC01;
      default: return {step - 4'd4, 8'h00};
    endcase
  endfunction

  assign w_step = (r_state == S_INIT) ? 4'd0 : r_step + 4'd1;
`endif

  always_comb begin
    w_frame = build_frame(wr.wr_bcast, wr.wr_dev, {wr.wr_addr, wr.wr_data});
`ifdef MAX7219_AUTOINIT_EN
    if (r_state != S_IDLE) w_frame = build_frame(1'b1, '0, init_word(w_step));
`endif
  end

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_INIT;
      r_tick  <= '0;
      r_bit   <= '0;
      r_hold  <= '0;
      r_frame <= '0;
      r_ready <= 1'b0;
      r_busy  <= 1'b1;
      r_done  <= 1'b0;
      r_din   <= 1'b0;
      r_sck   <= 1'b0;
      r_load  <= 1'b0;
`ifdef MAX7219_AUTOINIT_EN
      r_step  <= '0;
`endif
    end else begin
      case (r_state)
        S_INIT: begin
`ifdef MAX7219_AUTOINIT_EN
          r_step  <= '0;
          r_frame <= w_frame;
          r_din   <= w_frame[FRAME_W-1];
          r_bit   <= BIT_FIRST;
          r_tick  <= '0;
          r_state <= S_SCK_LO;
`else
          r_state <= S_IDLE;
          r_ready <= 1'b1;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
`endif
        end
        S_IDLE: if (wr.wr_valid) begin
          r_frame <= w_frame;
          r_din   <= w_frame[FRAME_W-1];
          r_bit   <= BIT_FIRST;
          r_tick  <= '0;
          r_ready <= 1'b0;
          r_busy  <= 1'b1;
          r_state <= S_SCK_LO;
        end
        S_SCK_LO: if (r_tick == TICK_LAST) begin
          r_tick  <= '0;
          r_sck   <= 1'b1;
          r_state <= S_SCK_HI;
        end else r_tick <= r_tick + TICK_W'(1);
        S_SCK_HI: if (r_tick == TICK_LAST) begin
          r_tick <= '0;
          r_sck  <= 1'b0;
          if (r_bit != '0) begin
            r_bit   <= r_bit - BIT_W'(1);
            r_din   <= r_frame[r_bit - BIT_W'(1)];
            r_state <= S_SCK_LO;
          end else r_state <= S_TAIL;
        end else r_tick <= r_tick + TICK_W'(1);
        S_TAIL: if (r_tick == TICK_LAST) begin
          r_tick  <= '0;
          r_hold  <= '0;
          r_load  <= 1'b1;
          r_state <= S_LOAD;
        end else r_tick <= r_tick + TICK_W'(1);
        S_LOAD: if (r_hold == HOLD_LAST) begin
          r_hold <= '0;
          r_load <= 1'b0;
`ifdef MAX7219_AUTOINIT_EN
          // During init the next step's frame starts straight from LOAD.
          if (!r_done && (r_step != 4'd12)) begin
            r_step  <= w_step;
            r_frame <= w_frame;
            r_din   <= w_frame[FRAME_W-1];
            r_bit   <= BIT_FIRST;
            r_tick  <= '0;
            r_state <= S_SCK_LO;
          end else
`endif
          begin
            r_state <= S_IDLE;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end else r_hold <= r_hold + HOLD_W'(1);
        default: r_state <= S_INIT;
      endcase
    end
  end

  assign wr.wr_ready = r_ready;
  assign busy        = r_busy;
  assign init_done   = r_done;
  assign max_din     = r_din;
  assign max_clk     = r_sck;
  assign max_load    = r_load;
endmodule

// File: tb/tb_max7219_chain.sv
// Bench for max7219_chain: a 4-device chain and a 1-device chain, each observed
// by a shift-register/register-file model of the MAX7219 devices.
`timescale 1ns/1ps
module tb_max7219_chain;
  localparam int unsigned ND = 4, CD = 10, LH = 2, H = CD / 2, FW = ND * 16;
  localparam int unsigned CDB = 4, LHB = 1, HB = CDB / 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  max7219_chain_if #(.DEV_W(2)) bus_a ();
  max7219_chain_if #(.DEV_W(1)) bus_b ();
  logic a_busy, a_done, a_din, a_sck, a_load;
  logic b_busy, b_done, b_din, b_sck, b_load;

  max7219_chain #(.NUM_DEV(ND), .CLK_DIV(CD), .LOAD_HOLD(LH), .INTENSITY(4'd12),
                  .SCAN_LIMIT(3'd7), .DECODE(8'h00)) dut_a (
    .CLOCK_50(clk), .rst_n(rst_n), .wr(bus_a), .busy(a_busy), .init_done(a_done),
    .max_din(a_din), .max_clk(a_sck), .max_load(a_load));

  max7219_chain #(.NUM_DEV(1), .CLK_DIV(CDB), .LOAD_HOLD(LHB)) dut_b (
    .CLOCK_50(clk), .rst_n(rst_n), .wr(bus_b), .busy(b_busy), .init_done(b_done),
    .max_din(b_din), .max_clk(b_sck), .max_load(b_load));

  int unsigned n_checks = 0, n_fail = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Device models: shift on max_clk rise, latch and decode on max_load rise.
  logic [FW-1:0] a_chain = '0;
  logic [15:0]   b_chain = '0;
  logic [FW-1:0] a_lat_q[$];
  logic [15:0]   b_lat_q[$];
  int unsigned a_bits = 0, b_bits = 0, a_first_sck = 0, a_load_cyc = 0, b_load_cyc = 0;
  int unsigned a_done_loads = 0;
  logic [7:0] a_reg[ND][16], e_reg_a[ND][16];
  logic [7:0] b_reg[16], e_reg_b[16];

  always @(posedge a_sck) begin
    if (a_bits == 0) a_first_sck = cyc;
    a_chain = {a_chain[FW-2:0], a_din};
    a_bits++;
  end
  always @(posedge a_load) begin
    check("a_frame_bits", a_bits, FW);
    a_bits = 0;
    a_load_cyc = cyc;
    if (a_done) a_done_loads++;
    a_lat_q.push_back(a_chain);
    for (int unsigned d = 0; d < ND; d++)
      if (a_chain[d*16+8 +: 4] != 4'h0) a_reg[d][a_chain[d*16+8 +: 4]] = a_chain[d*16 +: 8];
  end
  always @(posedge b_sck) begin
    b_chain = {b_chain[14:0], b_din};
    b_bits++;
  end
  always @(posedge b_load) begin
    check("b_frame_bits", b_bits, 16);
    b_bits = 0;
    b_load_cyc = cyc;
    b_lat_q.push_back(b_chain);
    if (b_chain[11:8] != 4'h0) b_reg[b_chain[11:8]] = b_chain[7:0];
  end
  always @(negedge rst_n) begin
    a_bits = 0;
    b_bits = 0;
  end

  logic [15:0] init_tbl[13] = '{16'h0F00, 16'h0B07, 16'h0900, 16'h0A0C, 16'h0C01,
                                16'h0100, 16'h0200, 16'h0300, 16'h0400, 16'h0500,
                                16'h0600, 16'h0700, 16'h0800};

  // Expected chain contents for one host write, and its effect on the registers.
  task automatic exp_a(input bit b, input int unsigned dv, input logic [3:0] a,
                       input logic [7:0] d, output logic [FW-1:0] c);
    c = '0;
    for (int unsigned i = 0; i < ND; i++)
      if (b || dv == i) begin
        c[i*16 +: 16] = {4'h0, a, d};
        if (a != 4'h0) e_reg_a[i][a] = d;
      end
  endtask

  task automatic check_reset_outs();
    check("a_reset_outs", {a_din, a_sck, a_load, bus_a.wr_ready, a_busy, a_done}, 6'b000010);
    check("b_reset_outs", {b_din, b_sck, b_load, bus_b.wr_ready, b_busy, b_done}, 6'b000010);
  endtask

  task automatic release_and_init();
    logic [FW-1:0] c;
    int unsigned t;
    a_lat_q.delete();
    b_lat_q.delete();
    a_done_loads = 0;
    @(negedge clk);
    rst_n = 1'b1;
`ifdef MAX7219_AUTOINIT_EN
    t = 0;
    while (!(a_done && b_done) && t < 20000) begin
      @(negedge clk);
      check("init_busy_a", a_busy, !a_done);
      t++;
    end
    check("init_done_a", a_done, 1);
    check("init_done_b", b_done, 1);
    check("init_loads_a", a_lat_q.size(), 13);
    check("init_done_early", a_done_loads, 0);
    for (int unsigned s = 0; s < 13; s++) begin
      exp_a(1'b1, 0, init_tbl[s][11:8], init_tbl[s][7:0], c);
      check("init_frame_a", a_lat_q[s], c);
    end
    check("init_loads_b", b_lat_q.size(), 13);
    check("init_first_b", b_lat_q[0], 16'h0F00);
    check("init_last_b", b_lat_q[12], 16'h0800);
    for (int unsigned s = 0; s < 13; s++)
      if (init_tbl[s][11:8] != 4'h0) e_reg_b[init_tbl[s][11:8]] = init_tbl[s][7:0];
`else
    @(posedge clk);
    #1;
    check("init_done_a_next", {a_done, bus_a.wr_ready, a_busy}, 3'b110);
    check("init_done_b_next", {b_done, bus_b.wr_ready, b_busy}, 3'b110);
    @(negedge clk);
    check("init_no_frames", a_lat_q.size() + b_lat_q.size(), 0);
`endif
  endtask

  task automatic rand_fields_a();
    bus_a.wr_bcast = 1'($urandom);
    bus_a.wr_dev   = 2'($urandom);
    bus_a.wr_addr  = 4'($urandom);
    bus_a.wr_data  = 8'($urandom);
  endtask

  // One host write on chain A. With hold=1, wr_valid stays high with garbage
  // fields throughout, and the task returns on the cycle wr_ready comes back.
  task automatic transact_a(input bit b, input int unsigned dv, input logic [3:0] a,
                            input logic [7:0] d, input bit hold);
    int unsigned t, t_acc, n0, rdy_hi;
    logic [FW-1:0] c;
    t = 0;
    while (!bus_a.wr_ready && t < 3000) begin @(negedge clk); t++; end
    check("a_ready_wait", bus_a.wr_ready, 1);
    bus_a.wr_valid = 1'b1;
    bus_a.wr_bcast = b;
    bus_a.wr_dev   = 2'(dv);
    bus_a.wr_addr  = a;
    bus_a.wr_data  = d;
    t_acc = cyc;
    n0 = a_lat_q.size();
    exp_a(b, dv, a, d, c);
    @(negedge clk);
    check("a_ready_drop", bus_a.wr_ready, 0);
    t = 0;
    rdy_hi = 0;
    while (a_lat_q.size() == n0 && t < 3000) begin
      if (hold) rand_fields_a(); else bus_a.wr_valid = 1'b0;
      @(negedge clk);
      if (bus_a.wr_ready) rdy_hi++;
      t++;
    end
    check("a_load_count", a_lat_q.size(), n0 + 1);
    check("a_frame", a_lat_q[n0], c);
    check("a_first_sck", a_first_sck, t_acc + 1 + H);
    check("a_load_time", a_load_cyc, t_acc + 1 + FW * CD + H);
    check("a_ready_low", rdy_hi, 0);
    t = 0;
    while (!bus_a.wr_ready && t < 100) begin
      if (hold) rand_fields_a();
      @(negedge clk);
      t++;
    end
    check("a_ready_back", cyc, a_load_cyc + LH);
  endtask

  initial begin
    int unsigned t, n0, t_acc, bad;
    logic [3:0] ra;
    logic [7:0] rd;
    bus_a.wr_valid = 1'b0; bus_a.wr_bcast = 1'b0; bus_a.wr_dev = '0;
    bus_a.wr_addr = '0; bus_a.wr_data = '0;
    bus_b.wr_valid = 1'b0; bus_b.wr_bcast = 1'b0; bus_b.wr_dev = '0;
    bus_b.wr_addr = '0; bus_b.wr_data = '0;
    for (int unsigned r = 0; r < 16; r++) begin
      for (int unsigned d = 0; d < ND; d++) begin a_reg[d][r] = '0; e_reg_a[d][r] = '0; end
      b_reg[r] = '0;
      e_reg_b[r] = '0;
    end

    repeat (3) @(negedge clk);
    check_reset_outs();
    release_and_init();

    // Single target, broadcast, then held wr_valid with changing fields.
    transact_a(1'b0, 2, 4'h1, 8'h5A, 1'b0);
    transact_a(1'b1, $urandom_range(0, 3), 4'hA, 8'h03, 1'b0);
    transact_a(1'b0, 1, 4'h3, 8'hC3, 1'b1);
    transact_a(1'b0, 3, 4'h5, 8'h77, 1'b0);

    for (int unsigned i = 0; i < 12; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      transact_a(($urandom_range(0, 3) == 0), $urandom_range(0, 3), 4'($urandom),
                 8'($urandom), 1'b0);
    end

    // Reset in the middle of a frame.
    t = 0;
    while (!bus_a.wr_ready && t < 3000) begin @(negedge clk); t++; end
    bus_a.wr_valid = 1'b1; bus_a.wr_bcast = 1'b1; bus_a.wr_addr = 4'h4; bus_a.wr_data = 8'hEE;
    @(negedge clk);
    bus_a.wr_valid = 1'b0;
    n0 = a_lat_q.size();
    t = 0;
    while (a_bits < 30 && t < 3000) begin @(negedge clk); t++; end
    check("a_reached_bit30", a_bits, 30);
    #1 rst_n = 1'b0;
    #1 check_reset_outs();
    repeat (20) @(negedge clk);
    check("a_no_load_in_reset", a_lat_q.size(), n0);
    check_reset_outs();
    release_and_init();
    transact_a(1'b0, 0, 4'h2, 8'h81, 1'b0);

    // Single-device chain, out-of-range target: full no-op frame, registers untouched.
    t = 0;
    while (!bus_b.wr_ready && t < 3000) begin @(negedge clk); t++; end
    check("b_ready_wait", bus_b.wr_ready, 1);
    ra = 4'($urandom_range(1, 15));
    rd = 8'($urandom);
    bus_b.wr_valid = 1'b1; bus_b.wr_bcast = 1'b0; bus_b.wr_dev = 1'b1;
    bus_b.wr_addr = ra; bus_b.wr_data = rd;
    t_acc = cyc;
    n0 = b_lat_q.size();
    @(negedge clk);
    bus_b.wr_valid = 1'b0;
    t = 0;
    while (b_lat_q.size() == n0 && t < 3000) begin @(negedge clk); t++; end
    check("b_frame", b_lat_q[n0], 16'h0000);
    check("b_load_time", b_load_cyc, t_acc + 1 + 16 * CDB + HB);
    t = 0;
    while (!bus_b.wr_ready && t < 100) begin @(negedge clk); t++; end
    check("b_ready_back", cyc, b_load_cyc + LHB);
    repeat (20) @(negedge clk);
    check("b_single_load", b_lat_q.size(), n0 + 1);

    bad = 0;
    for (int unsigned r = 0; r < 16; r++) begin
      for (int unsigned d = 0; d < ND; d++) if (a_reg[d][r] !== e_reg_a[d][r]) bad++;
    end
    check("a_regfile", bad, 0);
    bad = 0;
    for (int unsigned r = 0; r < 16; r++) if (b_reg[r] !== e_reg_b[r]) bad++;
    check("b_regfile", bad, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL watchdog cyc=%0d checks=%0d", cyc, n_checks);
    $fatal(1, "simulation time limit reached");
  end
endmodule
